// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the mini-cpu: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath mux selects.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_ctrl,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        instr_done,
    output logic        halted,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR,
        S_MEM_RD, S_WB_LD, S_MEM_WR, S_BRANCH, S_TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;

    state_t      state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        halted_q, halted_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r, is_ld, is_sd, is_beq;
    logic [2:0] alu_r;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    // IR is stable from DECODE until the instruction retires, so the decode
    // is purely combinational and reused by EXEC_R.
    always_comb begin
        is_r  = 1'b0;
        alu_r = ALU_ADD;
        if (opcode == 7'd51) begin
            unique case ({funct3, funct7})
                {3'd0, 7'd0}:  begin is_r = 1'b1; alu_r = ALU_ADD; end
                {3'd0, 7'd32}: begin is_r = 1'b1; alu_r = ALU_SUB; end
                {3'd6, 7'd0}:  begin is_r = 1'b1; alu_r = ALU_AND; end
                {3'd7, 7'd0}:  begin is_r = 1'b1; alu_r = ALU_OR;  end
                default:       is_r = 1'b0;
            endcase
        end
    end

    assign is_ld  = (opcode == 7'd3)  && (funct3 == 3'd3);
    assign is_sd  = (opcode == 7'd35) && (funct3 == 3'd3);
    assign is_beq = (opcode == 7'd99) && (funct3 == 3'd0);

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        state_d    = state_q;
        halted_d   = halted_q;

        unique case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                if (is_r)                 state_d = S_EXEC_R;
                else if (is_ld || is_sd)  state_d = S_ADDR;
                else if (is_beq)          state_d = S_BRANCH;
                else begin
                    state_d  = S_TRAP;
                    halted_d = 1'b1;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = alu_r;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = is_ld ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_WB_LD;
            end
            S_WB_LD: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = ALU_SUB;
                pc_write   = alu_zero;
                pc_src     = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        // run is only looked at when an instruction retires
        if (instr_done) state_d = run ? S_FETCH : S_IDLE;
        retired_d = retired_q + {31'd0, instr_done};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            retired_q <= 32'd0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            halted_q  <= halted_d;
        end
    end

    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the full strobe vector against hand-built expectations.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, alu_zero, mem_ready;
    logic [31:0] instr;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_ctrl;
    logic        reg_write, mem_to_reg, instr_done, halted;
    logic [31:0] retired;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .halted(halted), .retired(retired)
    );

    logic [15:0] outs;
    assign outs = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                   alu_src_b, alu_ctrl, reg_write, mem_to_reg, instr_done, halted};

    function automatic logic [15:0] ov(input logic mr, we, io, irw, pcw, pcs, sa,
                                       input logic [1:0] sb, input logic [2:0] ac,
                                       input logic rw, m2r, dn, h);
        return {mr, we, io, irw, pcw, pcs, sa, sb, ac, rw, m2r, dn, h};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [15:0] exp);
        @(negedge clk);
        chk(tag, {16'd0, outs}, {16'd0, exp});
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h402081B3;
    localparam logic [31:0] I_LD  = 32'h0030B103;
    localparam logic [31:0] I_SD  = 32'h0020B423;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_ILL = 32'h00000013;

    logic [15:0] O_IDLE, O_FRDY, O_FWAIT, O_DEC, O_EXADD, O_EXSUB, O_WBR, O_ADDR,
                 O_MRD, O_WBLD, O_MWR, O_BR1, O_BR0, O_TRAP;

    initial begin
        O_IDLE  = '0;
        O_FRDY  = ov(1,0,0,1,1,0,0,2'b01,3'b010,0,0,0,0);
        O_FWAIT = ov(1,0,0,0,0,0,0,2'b00,3'b000,0,0,0,0);
        O_DEC   = ov(0,0,0,0,0,0,0,2'b11,3'b010,0,0,0,0);
        O_EXADD = ov(0,0,0,0,0,0,1,2'b00,3'b010,0,0,0,0);
        O_EXSUB = ov(0,0,0,0,0,0,1,2'b00,3'b110,0,0,0,0);
        O_WBR   = ov(0,0,0,0,0,0,0,2'b00,3'b000,1,0,1,0);
        O_ADDR  = ov(0,0,0,0,0,0,1,2'b10,3'b010,0,0,0,0);
        O_MRD   = ov(1,0,1,0,0,0,0,2'b00,3'b000,0,0,0,0);
        O_WBLD  = ov(0,0,0,0,0,0,0,2'b00,3'b000,1,1,1,0);
        O_MWR   = ov(1,1,1,0,0,0,0,2'b00,3'b000,0,0,1,0);
        O_BR1   = ov(0,0,0,0,1,1,1,2'b00,3'b110,0,0,1,0);
        O_BR0   = ov(0,0,0,0,0,1,1,2'b00,3'b110,0,0,1,0);
        O_TRAP  = ov(0,0,0,0,0,0,0,2'b00,3'b000,0,0,0,1);

        rst = 1'b1; run = 1'b1; mem_ready = 1'b1; alu_zero = 1'b0; instr = I_ADD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {16'd0, outs}, {16'd0, O_IDLE});
        chk("reset_retired", retired, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // add, zero-wait: 4 cycles
        cyc("add_fetch", O_FRDY);
        cyc("add_decode", O_DEC);
        cyc("add_exec", O_EXADD);
        cyc("add_wb", O_WBR);
        chk("add_retired", retired, 32'd1);

        // ld with 3 wait cycles in MEM_RD: 8 cycles
        instr = I_LD;
        cyc("ld_fetch", O_FRDY);
        cyc("ld_decode", O_DEC);
        cyc("ld_addr", O_ADDR);
        mem_ready = 1'b0;
        cyc("ld_mrd_w0", O_MRD);
        cyc("ld_mrd_w1", O_MRD);
        cyc("ld_mrd_w2", O_MRD);
        mem_ready = 1'b1;
        cyc("ld_mrd_rdy", O_MRD);
        cyc("ld_wb", O_WBLD);
        chk("ld_retired", retired, 32'd2);

        // sd, zero-wait: 4 cycles
        instr = I_SD;
        cyc("sd_fetch", O_FRDY);
        cyc("sd_decode", O_DEC);
        cyc("sd_addr", O_ADDR);
        cyc("sd_mwr", O_MWR);
        chk("sd_retired", retired, 32'd3);

        // beq taken then not taken: 3 cycles each
        instr = I_BEQ; alu_zero = 1'b1;
        cyc("beq1_fetch", O_FRDY);
        cyc("beq1_decode", O_DEC);
        cyc("beq1_branch", O_BR1);
        chk("beq1_retired", retired, 32'd4);
        alu_zero = 1'b0;
        cyc("beq0_fetch", O_FRDY);
        cyc("beq0_decode", O_DEC);
        cyc("beq0_branch", O_BR0);
        chk("beq0_retired", retired, 32'd5);

        // sub with run dropped in EXEC_R: completes, then parks in IDLE
        instr = I_SUB;
        cyc("sub_fetch", O_FRDY);
        cyc("sub_decode", O_DEC);
        run = 1'b0;
        cyc("sub_exec", O_EXSUB);
        cyc("sub_wb", O_WBR);
        chk("sub_retired", retired, 32'd6);
        cyc("idle_norun", O_IDLE);
        run = 1'b1;
        cyc("idle_run", O_IDLE);

        // fetch wait cycle, then illegal opcode traps
        instr = I_ILL; mem_ready = 1'b0;
        cyc("ill_fetch_wait", O_FWAIT);
        mem_ready = 1'b1;
        cyc("ill_fetch", O_FRDY);
        cyc("ill_decode", O_DEC);
        cyc("trap_0", O_TRAP);
        cyc("trap_1", O_TRAP);
        cyc("trap_2", O_TRAP);
        chk("trap_retired", retired, 32'd6);

        // reset clears halted asynchronously
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("trap_rst_outs", {16'd0, outs}, {16'd0, O_IDLE});
        chk("trap_rst_retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of an instruction
        instr = I_ADD;
        cyc("mid_fetch", O_FRDY);
        @(negedge clk);
        chk("mid_decode", {16'd0, outs}, {16'd0, O_DEC});
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {16'd0, outs}, {16'd0, O_IDLE});
        @(posedge clk); #1;
        chk("mid_rst_hold", {16'd0, outs}, {16'd0, O_IDLE});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
